// File: rtl/regfile_writeback.sv
// CR16 writeback stage: merges in-order load returns and ALU results into one
// register-file write per cycle, and tracks registers with loads in flight.
module regfile_writeback #(
    parameter int LOAD_DEPTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 16
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic                         I_ALU_VALID,
    input  logic [$clog2(REG_COUNT)-1:0] I_ALU_DEST,
    input  logic [DATA_WIDTH-1:0]        I_ALU_RESULT,
    output logic                         O_ALU_READY,
    input  logic                         I_LOAD_ISSUE,
    input  logic [$clog2(REG_COUNT)-1:0] I_LOAD_DEST,
    output logic                         O_LOAD_READY,
    input  logic                         I_MEM_VALID,
    input  logic [DATA_WIDTH-1:0]        I_MEM_DATA,
    output logic [DATA_WIDTH-1:0]        O_REG_BUS,
    output logic [REG_COUNT-1:0]         O_REG_ENABLE,
    output logic [REG_COUNT-1:0]         O_REG_BUSY,
    output logic                         O_ERR
);
    localparam int DEST_W = $clog2(REG_COUNT);
    localparam int PTR_W  = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;

    logic [DEST_W-1:0]     fifo_mem_q [LOAD_DEPTH];
    logic [DEST_W-1:0]     fifo_mem_d [LOAD_DEPTH];
    logic [LOAD_DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DEST_W-1:0]     skid_dest_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [DATA_WIDTH-1:0] reg_bus_q, reg_bus_d;
    logic [REG_COUNT-1:0]  reg_en_q, reg_en_d;
    logic [REG_COUNT-1:0]  reg_busy_q, reg_busy_d;
    logic                  err_q, err_d;

    logic                  fifo_full, fifo_empty;
    logic                  mem_pop, alu_acc, load_push, skid_load;
    logic                  wr_en;
    logic [DEST_W-1:0]     wr_dest;

    always_comb begin
        // Per-slot valid bits make full/empty a single lookup at each pointer.
        fifo_full  = slot_vld_q[wr_ptr_q];
        fifo_empty = !slot_vld_q[rd_ptr_q];
        mem_pop    = I_MEM_VALID && !fifo_empty;
        alu_acc    = I_ALU_VALID && !skid_vld_q;
        load_push  = I_LOAD_ISSUE && !fifo_full;

        fifo_mem_d = fifo_mem_q;
        slot_vld_d = slot_vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (mem_pop) begin
            slot_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + PTR_W'(1);
        end
        if (load_push) begin
            fifo_mem_d[wr_ptr_q] = I_LOAD_DEST;
            slot_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        wr_en      = 1'b0;
        wr_dest    = '0;
        reg_bus_d  = reg_bus_q;
        skid_vld_d = skid_vld_q;
        skid_load  = 1'b0;
        if (mem_pop) begin
            wr_en     = 1'b1;
            wr_dest   = fifo_mem_q[rd_ptr_q];
            reg_bus_d = I_MEM_DATA;
            if (alu_acc) begin
                skid_vld_d = 1'b1;
                skid_load  = 1'b1;
            end
        end else if (skid_vld_q) begin
            wr_en      = 1'b1;
            wr_dest    = skid_dest_q;
            reg_bus_d  = skid_data_q;
            skid_vld_d = 1'b0;
        end else if (alu_acc) begin
            wr_en     = 1'b1;
            wr_dest   = I_ALU_DEST;
            reg_bus_d = I_ALU_RESULT;
        end

        reg_en_d = '0;
        if (wr_en) reg_en_d[wr_dest] = 1'b1;

        // Busy reflects the FIFO as it will stand after this edge.
        reg_busy_d = '0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            if (slot_vld_d[i]) reg_busy_d[fifo_mem_d[i]] = 1'b1;
        end

        err_d = err_q || (I_MEM_VALID && fifo_empty);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            slot_vld_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            skid_vld_q <= 1'b0;
            reg_bus_q  <= '0;
            reg_en_q   <= '0;
            reg_busy_q <= '0;
            err_q      <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            skid_vld_q <= skid_vld_d;
            reg_bus_q  <= reg_bus_d;
            reg_en_q   <= reg_en_d;
            reg_busy_q <= reg_busy_d;
            err_q      <= err_d;
        end
    end

    // Payload storage is qualified by the valid bits above, so it needs no reset.
    always_ff @(posedge I_CLK) begin
        fifo_mem_q <= fifo_mem_d;
        if (skid_load) begin
            skid_dest_q <= I_ALU_DEST;
            skid_data_q <= I_ALU_RESULT;
        end
    end

    assign O_ALU_READY  = !skid_vld_q;
    assign O_LOAD_READY = !fifo_full;
    assign O_REG_BUS    = reg_bus_q;
    assign O_REG_ENABLE = reg_en_q;
    assign O_REG_BUSY   = reg_busy_q;
    assign O_ERR        = err_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: per-cycle vectors with hand-derived expected
// outputs, queued when driven and compared one edge later.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [15:0] alu_result;
    logic        alu_ready;
    logic        load_issue;
    logic [3:0]  load_dest;
    logic        load_ready;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic [15:0] reg_bus;
    logic [15:0] reg_enable;
    logic [15:0] reg_busy;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ad;
        logic [15:0] ar;
        logic        li;
        logic [3:0]  ld;
        logic        mv;
        logic [15:0] md;
        logic [15:0] en;
        logic [15:0] bus;
        logic [15:0] busy;
        logic        ardy;
        logic        lrdy;
        logic        err;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[16];

    regfile_writeback #(.LOAD_DEPTH(2), .DATA_WIDTH(16), .REG_COUNT(16)) dut (
        .I_CLK(clk), .I_RESET(rst),
        .I_ALU_VALID(alu_valid), .I_ALU_DEST(alu_dest), .I_ALU_RESULT(alu_result),
        .O_ALU_READY(alu_ready),
        .I_LOAD_ISSUE(load_issue), .I_LOAD_DEST(load_dest), .O_LOAD_READY(load_ready),
        .I_MEM_VALID(mem_valid), .I_MEM_DATA(mem_data),
        .O_REG_BUS(reg_bus), .O_REG_ENABLE(reg_enable), .O_REG_BUSY(reg_busy),
        .O_ERR(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic av, input logic [3:0] ad,
                                input logic [15:0] ar, input logic li, input logic [3:0] ld,
                                input logic mv, input logic [15:0] md, input logic [15:0] en,
                                input logic [15:0] bus, input logic [15:0] busy,
                                input logic ardy, input logic lrdy, input logic e);
        vec_t v;
        v.rst = r; v.av = av; v.ad = ad; v.ar = ar; v.li = li; v.ld = ld;
        v.mv = mv; v.md = md; v.en = en; v.bus = bus; v.busy = busy;
        v.ardy = ardy; v.lrdy = lrdy; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input int step_id, input logic [15:0] act,
                       input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step_id, act, req);
        end
    endtask

    task automatic step(input int id, input vec_t v);
        vec_t e;
        rst        = v.rst;
        alu_valid  = v.av;
        alu_dest   = v.ad;
        alu_result = v.ar;
        load_issue = v.li;
        load_dest  = v.ld;
        mem_valid  = v.mv;
        mem_data   = v.md;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("reg_enable", id, reg_enable, e.en);
        chk("reg_bus",    id, reg_bus,    e.bus);
        chk("reg_busy",   id, reg_busy,   e.busy);
        chk("alu_ready",  id, {15'd0, alu_ready},  {15'd0, e.ardy});
        chk("load_ready", id, {15'd0, load_ready}, {15'd0, e.lrdy});
        chk("err",        id, {15'd0, err},        {15'd0, e.err});
    endtask

    initial begin
        //             rst av ad  ar        li ld  mv md        en        bus       busy      ar lr er
        tbl[0]  = mk(1, 0, 0,  16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0);
        tbl[1]  = mk(0, 1, 3,  16'h1234, 0, 0,  0, 16'h0000, 16'h0008, 16'h1234, 16'h0000, 1, 1, 0);
        tbl[2]  = mk(0, 0, 0,  16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0,  16'h0000, 1, 5,  0, 16'h0000, 16'h0000, 16'h1234, 16'h0020, 1, 1, 0);
        tbl[4]  = mk(0, 0, 0,  16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 16'h1234, 16'h0020, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0,  16'h0000, 0, 0,  1, 16'hBEEF, 16'h0020, 16'hBEEF, 16'h0000, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0,  16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1, 1, 0);
        tbl[7]  = mk(0, 0, 0,  16'h0000, 1, 2,  0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0004, 1, 1, 0);
        tbl[8]  = mk(0, 1, 7,  16'h0077, 0, 0,  1, 16'h00AA, 16'h0004, 16'h00AA, 16'h0000, 0, 1, 0);
        tbl[9]  = mk(0, 1, 8,  16'h0888, 0, 0,  0, 16'h0000, 16'h0080, 16'h0077, 16'h0000, 1, 1, 0);
        tbl[10] = mk(0, 1, 8,  16'h0888, 0, 0,  0, 16'h0000, 16'h0100, 16'h0888, 16'h0000, 1, 1, 0);
        tbl[11] = mk(0, 0, 0,  16'h0000, 1, 6,  0, 16'h0000, 16'h0000, 16'h0888, 16'h0040, 1, 1, 0);
        tbl[12] = mk(0, 0, 0,  16'h0000, 1, 10, 0, 16'h0000, 16'h0000, 16'h0888, 16'h0440, 1, 0, 0);
        tbl[13] = mk(0, 1, 11, 16'h0BBB, 0, 0,  1, 16'h1111, 16'h0040, 16'h1111, 16'h0400, 0, 1, 0);
        tbl[14] = mk(0, 0, 0,  16'h0000, 0, 0,  1, 16'h2222, 16'h0400, 16'h2222, 16'h0000, 0, 1, 0);
        tbl[15] = mk(0, 0, 0,  16'h0000, 0, 0,  0, 16'h0000, 16'h0800, 16'h0BBB, 16'h0000, 1, 1, 0);

        for (int i = 0; i < 16; i++) step(i, tbl[i]);

        // Duplicate destinations, full FIFO dropping issues, then an orphan return.
        step(100, mk(0, 0, 0, 16'h0000, 1, 1,  0, 16'h0000, 16'h0000, 16'h0BBB, 16'h0002, 1, 1, 0));
        step(101, mk(0, 0, 0, 16'h0000, 1, 1,  0, 16'h0000, 16'h0000, 16'h0BBB, 16'h0002, 1, 0, 0));
        step(102, mk(0, 0, 0, 16'h0000, 1, 12, 0, 16'h0000, 16'h0000, 16'h0BBB, 16'h0002, 1, 0, 0));
        step(103, mk(0, 0, 0, 16'h0000, 1, 12, 1, 16'h0A01, 16'h0002, 16'h0A01, 16'h0002, 1, 1, 0));
        step(104, mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h0A02, 16'h0002, 16'h0A02, 16'h0000, 1, 1, 0));
        step(105, mk(0, 0, 0, 16'h0000, 0, 0,  1, 16'h0A03, 16'h0000, 16'h0A02, 16'h0000, 1, 1, 1));
        step(106, mk(0, 0, 0, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 16'h0A02, 16'h0000, 1, 1, 1));
        step(107, mk(0, 1, 3, 16'h0333, 0, 0,  0, 16'h0000, 16'h0008, 16'h0333, 16'h0000, 1, 1, 1));
        step(108, mk(1, 0, 0, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0));

        // Reset while a load is pending and the skid holds an ALU result.
        step(200, mk(0, 0, 0,  16'h0000, 1, 4, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 1, 1, 0));
        step(201, mk(0, 0, 0,  16'h0000, 1, 9, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0210, 1, 0, 0));
        step(202, mk(0, 1, 14, 16'h0EEE, 0, 0, 1, 16'h3333, 16'h0010, 16'h3333, 16'h0200, 0, 1, 0));
        step(203, mk(0, 0, 0,  16'h0000, 1, 4, 1, 16'h4444, 16'h0200, 16'h4444, 16'h0010, 0, 1, 0));
        step(204, mk(1, 1, 1,  16'h0111, 1, 9, 1, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0));
        step(205, mk(0, 0, 0,  16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0));
        step(206, mk(0, 0, 0,  16'h0000, 0, 0, 1, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
